// File: rtl/proc_datapath.sv
// Processor datapath: R0-R3, operand Rh, result Rl, add/sub and XOR units on a shared bus,
// plus a tracker for the Rh-load -> Rl-compute -> Rl-writeback sequence.
// Optional: define PROC_DATAPATH_OVERFLOW_EN to add the signed-overflow output `overflow`.
module proc_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_out,
  input  logic [3:0]       R_out,
  input  logic [3:0]       R_in,
  input  logic             Rh_in,
  input  logic             Rl_in,
  input  logic             Rl_out,
  input  logic             AddSub,
  input  logic             AS_enable,
  input  logic             XOR_enable,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic             carry,
  output logic             zero,
  output logic             op_done,
  output logic             bus_conflict,
  output logic             seq_err
`ifdef PROC_DATAPATH_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_A    = 2'd1;
  localparam logic [1:0] OP_R    = 2'd2;

  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] rh;
  logic [WIDTH-1:0] rl;
  logic [1:0]       state;
  logic [1:0]       state_next;

  logic [2:0]       driver_count;
  logic             conflict;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             en_mismatch;

  logic             rl_load;
  logic             seq_viol;
  logic             done_next;

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];

  // Every bus source counts, including several R_out bits at once.
  assign driver_count = {2'b00, data_out}
                      + {2'b00, R_out[0]} + {2'b00, R_out[1]}
                      + {2'b00, R_out[2]} + {2'b00, R_out[3]}
                      + {2'b00, Rl_out};
  assign conflict = driver_count > 3'd1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    bus = '0;
    if (!conflict) begin
      if (data_out) bus = data_in;
      for (int i = 0; i < 4; i++) begin
        if (R_out[i]) bus = regs[i];
      end
      if (Rl_out) bus = rl;
    end
  end

  // The extra top bit is the carry on add and the borrow (Rh < bus) on subtract.
  assign sum  = {1'b0, rh} + {1'b0, bus};
  assign diff = {1'b0, rh} - {1'b0, bus};

  always_comb begin
    alu_result  = bus;
    alu_carry   = 1'b0;
    en_mismatch = 1'b0;
    case (sel)
      2'b00, 2'b01: begin
        if (AS_enable) begin
          alu_result = AddSub ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
          alu_carry  = AddSub ? diff[WIDTH]     : sum[WIDTH];
        end else begin
          en_mismatch = 1'b1;
        end
      end
      2'b10: begin
        if (XOR_enable) alu_result = rh ^ bus;
        else            en_mismatch = 1'b1;
      end
      default: ;
    endcase
  end

  // Rh_in wins over Rl_in in the same cycle: Rl is left alone.
  assign rl_load = Rl_in && !Rh_in;

  always_comb begin
    state_next = state;
    seq_viol   = 1'b0;
    done_next  = 1'b0;
    if (Rl_out && state != OP_R) seq_viol = 1'b1;
    if (Rl_in && (Rh_in || Rl_out || state == OP_IDLE || en_mismatch)) seq_viol = 1'b1;
    if (Rh_in) begin
      state_next = OP_A;
    end else if (Rl_in) begin
      if (!Rl_out && state == OP_A) state_next = OP_R;
    end else if (Rl_out && state == OP_R) begin
      state_next = OP_IDLE;
      done_next  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the register file is four plain flop words, not a RAM macro, so it resets like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      rh           <= '0;
      rl           <= '0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      op_done      <= 1'b0;
      bus_conflict <= 1'b0;
      seq_err      <= 1'b0;
      state        <= OP_IDLE;
    end else begin
      op_done <= done_next && !conflict;
      if (conflict) begin
        bus_conflict <= 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (R_in[i]) regs[i] <= bus;
        end
        if (Rh_in) rh <= bus;
        if (rl_load) begin
          rl    <= alu_result;
          carry <= alu_carry;
          zero  <= (alu_result == '0);
        end
        if (seq_viol) seq_err <= 1'b1;
        state <= state_next;
      end
    end
  end

`ifdef PROC_DATAPATH_OVERFLOW_EN
  logic ovf_add;
  logic ovf_sub;

  assign ovf_add = (rh[WIDTH-1] == bus[WIDTH-1]) && (sum[WIDTH-1]  != rh[WIDTH-1]);
  assign ovf_sub = (rh[WIDTH-1] != bus[WIDTH-1]) && (diff[WIDTH-1] != rh[WIDTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (!conflict && rl_load) begin
      overflow <= (!sel[1] && AS_enable) ? (AddSub ? ovf_sub : ovf_add) : 1'b0;
    end
  end
`endif

endmodule
